// File: rtl/isomap_fwd_seq.sv
// isomap_fwd_seq: maps each AES state byte from GF(2^8) polynomial basis into GF((2^4)^2), BYTES_PER_CYCLE bytes per cycle
// Ports: clk / rst_n (async active-low) clock and reset
//        in_valid_i / in_ready_o / in_data_i    128-bit input block handshake, byte i = in_data_i[8i+7:8i]
//        out_valid_o / out_ready_i / out_data_o 128-bit mapped block handshake, same byte ordering
//        busy_o                                 high while chunks are being mapped
module isomap_fwd_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);
  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, MAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  data_q, data_d, data_map;
  function automatic logic [7:0] fwd(input logic [7:0] a);
    return {a[7]^a[5],
            a[7]^a[6]^a[4]^a[3]^a[2]^a[1],
            a[7]^a[5]^a[3]^a[2],
            a[7]^a[5]^a[3]^a[2]^a[1],
            a[7]^a[6]^a[2]^a[1],
            a[7]^a[4]^a[3]^a[2]^a[1],
            a[6]^a[4]^a[1],
            a[6]^a[1]^a[0]};
  endfunction
  // only the lanes of the chunk selected by the counter are rewritten; the rest pass through
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_map[8*i +: 8] = (cnt_q == CW'(i / BYTES_PER_CYCLE)) ? fwd(data_q[8*i +: 8]) : data_q[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        data_d  = in_data_i;
        cnt_d   = '0;
        state_d = MAP;
      end
      MAP: begin
        data_d  = data_map;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1)) ? DONE : MAP;
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == MAP);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = data_q;
endmodule

// File: tb/tb_isomap_fwd_seq.sv
// tb_isomap_fwd_seq: randomized scoreboard bench for isomap_fwd_seq against a bit-matrix reference model
module tb_isomap_fwd_seq;
  localparam int BPC = 4;
  localparam int N   = 16 / BPC;
  // row k selects the input bits whose parity forms output bit k
  localparam logic [7:0] ROWS [8] = '{8'h43, 8'h52, 8'h9E, 8'hC6, 8'hAE, 8'hAC, 8'hDE, 8'hA0};
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  int           nvec = 0, nerr = 0, cyc = 0, acc_cyc = 0, first_acc = 0, last_acc = 0, distinct = 0;
  logic [127:0] exp_q[$], in_q[$];
  int           acc_q[$];
  logic [7:0]   inv [256];
  bit           seen [256];
  bit           ov_prev = 0;
  logic [127:0] m_e, m_src, m_rt, hold, d;
  logic [7:0]   y;
  isomap_fwd_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] fwd_ref(input logic [7:0] a);
    logic [7:0] q;
    for (int k = 0; k < 8; k++) q[k] = ^(a & ROWS[k]);
    return q;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_ref(v[8*i +: 8]);
    return r;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  // monitor: logs accepts into the scoreboard and checks every output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        in_q.push_back(in_data);
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) check("spurious_out_valid", 1, 0);
        else check("latency", 128'(cyc - acc_q.pop_front()), 128'(N));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          m_e   = exp_q.pop_front();
          m_src = in_q.pop_front();
          check("out_data", out_data, m_e);
          for (int i = 0; i < 16; i++) m_rt[8*i +: 8] = inv[out_data[8*i +: 8]];
          check("round_trip", m_rt, m_src);
        end
      end
    end
    ov_prev = out_valid;
  end
  task automatic send(input logic [127:0] v);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_valid = 1;
    in_data  = v;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        ok = 1;
      end
    end
    in_valid = 0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask
  task automatic wait_out();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 0);
  endtask
  task automatic const_test(input string name, input logic [7:0] a, input logic [7:0] q);
    send({16{a}});
    wait_out();
    check(name, out_data, {16{q}});
    drain();
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int x = 0; x < 256; x++) begin
      y = fwd_ref(8'(x));
      if (!seen[y]) distinct++;
      seen[y] = 1;
      inv[y]  = 8'(x);
    end
    check("map_bijective", 128'(distinct), 128'd256);
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    rst_n = 1;
    const_test("vec_00", 8'h00, 8'h00);
    const_test("vec_01", 8'h01, 8'h01);
    const_test("vec_02", 8'h02, 8'h5F);
    const_test("vec_80", 8'h80, 8'hFC);
    const_test("vec_ff", 8'hFF, 8'h17);
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(b * 16 + i);
      send(d);
    end
    drain();
    out_ready = 0;
    send(rnd128());
    wait_out();
    hold = out_data;
    @(posedge clk); #1;
    in_valid = 1;
    in_data  = rnd128();
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_data", out_data, hold);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after_handshake", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_second_accepted", busy, 1);
    drain();
    send(rnd128());
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_busy", busy, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    exp_q.delete();
    in_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    send(rnd128());
    drain();
    for (int s = 0; s < 100; s++) begin
      send(rnd128());
      if (s == 0) first_acc = acc_cyc;
      last_acc = acc_cyc;
    end
    check("stream_throughput", 128'(last_acc - first_acc), 128'(99 * (N + 2)));
    drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
